// File: rtl/mem_arb_rr_if.sv
// Bundle of requester-side and memory-side signals for the round-robin memory arbiter.
// slave = arbiter view; master = the requesters plus the memory bridge.
interface mem_arb_rr_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH*MASK_W-1:0] req_wmask;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [MASK_W-1:0]        mem_wmask;
    logic                     mem_rsp_valid;
    logic [DATA_W-1:0]        mem_rsp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter giving NUM_CH requesters one shared memory port, one transaction in flight.
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
//
//   state  | meaning
//   S_IDLE | no transaction; grant the next valid channel after last_grant
//   S_REQ  | mem_req_valid high with latched fields, waiting for mem_req_ready
//   S_WAIT | request accepted, waiting for mem_rsp_valid
module mem_arb_rr #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    mem_arb_rr_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2) begin : g_num_ch_check
        $error("NUM_CH must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     last_grant_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                mem_req_valid_q;
    logic [NUM_CH-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [CH_W-1:0]     winner;
    logic [CH_W-1:0]     scan_idx;
    logic                any_valid;
    logic                grant;
    logic [NUM_CH-1:0]   req_ready;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [MASK_W-1:0]   sel_wmask;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                tmo_hit;
    logic                rsp_err_q;
`endif

    // Scan starts one past the previous winner so every channel gets a turn.
    always_comb begin
        winner    = last_grant_q;
        scan_idx  = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_idx = CH_W'((int'(last_grant_q) + i) % NUM_CH);
            if (!any_valid && bus.req_valid[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign grant = rst && (state_q == S_IDLE) && any_valid;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (winner == CH_W'(c)) begin
                sel_we    = bus.req_we[c];
                sel_addr  = bus.req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[c*DATA_W +: DATA_W];
                sel_wmask = bus.req_wmask[c*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            last_grant_q    <= CH_W'(NUM_CH - 1);
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            rsp_err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        we_q            <= sel_we;
                        addr_q          <= sel_addr;
                        wdata_q         <= sel_wdata;
                        wmask_q         <= sel_wmask;
                        last_grant_q    <= winner;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_REQ;
                    end
                end
                S_REQ: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    if (tmo_hit) begin
                        mem_req_valid_q           <= 1'b0;
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_err_q                 <= 1'b1;
                        state_q                   <= S_IDLE;
                    end else
`endif
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A real response in the last watchdog cycle still wins over the abort.
                    if (bus.mem_rsp_valid) begin
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_rdata_q               <= we_q ? '0 : bus.mem_rsp_data;
                        state_q                   <= S_IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_err_q                 <= 1'b1;
                        state_q                   <= S_IDLE;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Down-counter loaded on grant; terminal count marks the TIMEOUT-th busy cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else if (grant) begin
            tmo_cnt_q <= TMO_W'(TIMEOUT - 1);
        end else if ((state_q != S_IDLE) && (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign tmo_hit     = (state_q != S_IDLE) && (tmo_cnt_q == '0);
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
endmodule

// File: tb/tb_mem_arb_rr.sv
// Bench for mem_arb_rr: directed scenarios plus randomized traffic against a queue-free
// round-robin reference model; inputs change 1 ns after posedge, outputs sampled 2 ns after.
module tb_mem_arb_rr;
    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arb_rr_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    mem_arb_rr #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state: pending requests held by requesters, and the round-robin pointer
    int                 exp_last;
    logic [NUM_CH-1:0]  pend;
    logic               we_a   [NUM_CH];
    logic [ADDR_W-1:0]  addr_a [NUM_CH];
    logic [DATA_W-1:0]  wd_a   [NUM_CH];
    logic [MASK_W-1:0]  wm_a   [NUM_CH];
    logic [NUM_CH-1:0]  exp_rsp;
    logic [DATA_W-1:0]  exp_rdata;
    logic               exp_err;
    logic               g_we;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wd;
    logic [MASK_W-1:0]  g_wm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm);
        pend[c]   = 1'b1;
        we_a[c]   = we;
        addr_a[c] = addr;
        wd_a[c]   = wd;
        wm_a[c]   = wm;
    endtask

    // Channels that are not requesting carry junk, so the DUT must rely on its own copy.
    task automatic drive_reqs();
        logic [NUM_CH-1:0]        we;
        logic [NUM_CH*ADDR_W-1:0] a;
        logic [NUM_CH*DATA_W-1:0] d;
        logic [NUM_CH*MASK_W-1:0] m;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!pend[c]) begin
                we_a[c]   = 1'($urandom);
                addr_a[c] = $urandom;
                wd_a[c]   = $urandom;
                wm_a[c]   = MASK_W'($urandom);
            end
            we[c]                 = we_a[c];
            a[c*ADDR_W +: ADDR_W] = addr_a[c];
            d[c*DATA_W +: DATA_W] = wd_a[c];
            m[c*MASK_W +: MASK_W] = wm_a[c];
        end
        bus.req_valid = pend;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    // Next owner: first pending channel in the rotation that starts after the last owner.
    function automatic int model_winner();
        for (int i = 1; i <= NUM_CH; i++) begin
            if (pend[(exp_last + i) % NUM_CH]) return (exp_last + i) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic check_rsp();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
        chk("rsp_err",   64'(bus.rsp_err),   64'(exp_err));
        exp_rsp   = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    task automatic idle_cycle();
        drive_reqs();
        bus.mem_req_ready = 1'($urandom);
        bus.mem_rsp_valid = 1'($urandom);
        bus.mem_rsp_data  = $urandom;
        #1;
        check_rsp();
        chk("idle_req_ready", 64'(bus.req_ready), 64'(0));
        chk("idle_mem_valid", 64'(bus.mem_req_valid), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic grant_cycle(output logic [NUM_CH-1:0] oh);
        int w;
        drive_reqs();
        bus.mem_req_ready = 1'($urandom);
        bus.mem_rsp_valid = 1'($urandom);
        bus.mem_rsp_data  = $urandom;
        #1;
        check_rsp();
        w  = model_winner();
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        chk("grant", 64'(bus.req_ready), 64'(oh));
        if (w >= 0) begin
            g_we     = we_a[w];
            g_addr   = addr_a[w];
            g_wd     = wd_a[w];
            g_wm     = wm_a[w];
            exp_last = w;
            pend[w]  = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic txn(input int acc_dly, input int rsp_dly, input logic [DATA_W-1:0] mdata, input bit abort);
        logic [NUM_CH-1:0] oh;
        grant_cycle(oh);
        for (int k = 0; k <= acc_dly; k++) begin
            drive_reqs();
            bus.mem_req_ready = (k == acc_dly);
            bus.mem_rsp_valid = 1'($urandom);
            bus.mem_rsp_data  = $urandom;
            #1;
            check_rsp();
            chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(1));
            chk("mem_we",        64'(bus.mem_we),        64'(g_we));
            chk("mem_addr",      64'(bus.mem_addr),      64'(g_addr));
            chk("mem_wdata",     64'(bus.mem_wdata),     64'(g_wd));
            chk("mem_wmask",     64'(bus.mem_wmask),     64'(g_wm));
            chk("req_ready_req", 64'(bus.req_ready),     64'(0));
            @(posedge clk); #1;
        end
        for (int k = 0; k <= rsp_dly; k++) begin
            drive_reqs();
            bus.mem_req_ready = 1'($urandom);
            bus.mem_rsp_valid = (k == rsp_dly);
            bus.mem_rsp_data  = (k == rsp_dly) ? mdata : $urandom;
            if (abort && k == rsp_dly) rst = 1'b0;
            #1;
            check_rsp();
            chk("mem_valid_wait", 64'(bus.mem_req_valid), 64'(0));
            chk("req_ready_wait", 64'(bus.req_ready),     64'(0));
            @(posedge clk); #1;
        end
        if (abort) begin
            rst      = 1'b1;
            exp_last = NUM_CH - 1;
            pend     = '0;
        end else begin
            exp_rsp   = oh;
            exp_rdata = g_we ? '0 : mdata;
            exp_err   = 1'b0;
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic tmo_txn();
        logic [NUM_CH-1:0] oh;
        grant_cycle(oh);
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive_reqs();
            bus.mem_req_ready = (k == 1);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
            #1;
            check_rsp();
            chk("tmo_mem_valid", 64'(bus.mem_req_valid), 64'(k == 1));
            @(posedge clk); #1;
        end
        exp_rsp   = oh;
        exp_rdata = '0;
        exp_err   = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        pend              = '0;
        exp_rsp           = '0;
        exp_rdata         = '0;
        exp_err           = 1'b0;
        exp_last          = NUM_CH - 1;
        bus.req_valid     = '0;
        bus.req_we        = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_wmask     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // reset: everything quiet, no combinational grant while rst is low
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready),     64'(0));
        chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'(0));
        check_rsp();
        bus.req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // ch0 and ch1 together from reset: ch0 read with minimum latency, then ch1
        set_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
        txn(0, 0, 32'h0000_0413, 1'b0);
        txn(0, 0, 32'h1111_2222, 1'b0);
        set_req(0, 1'b0, 32'h8000_0200, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h8000_0300, 32'h0, 4'hF);
        txn(0, 0, 32'h3333_4444, 1'b0);
        txn(0, 1, 32'h5555_6666, 1'b0);

        // ch1 write: fields forwarded exactly, read data reported as 0
        set_req(1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
        txn(0, 1, 32'hCAFE_F00D, 1'b0);

        // memory stalls accept for 5 cycles while ch0 keeps requesting
        set_req(2, 1'b0, 32'h8000_2000, 32'h0, 4'hF);
        set_req(0, 1'b1, 32'h8000_3000, 32'h0BAD_F00D, 4'b1100);
        txn(5, 0, 32'h7777_8888, 1'b0);
        txn(1, 0, 32'h9999_AAAA, 1'b0);
        idle_cycle();

        // reset during WAIT drops the response; pointer goes back to ch0-first
        set_req(0, 1'b0, 32'h8000_4000, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h8000_5000, 32'h0, 4'hF);
        txn(0, 2, 32'hBBBB_CCCC, 1'b1);
        idle_cycle();
        set_req(1, 1'b0, 32'h8000_6000, 32'h0, 4'hF);
        set_req(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        txn(0, 0, 32'h0000_0413, 1'b0);
        txn(0, 0, 32'hDDDD_EEEE, 1'b0);
        idle_cycle();

        // random traffic, including requesters withdrawing while losing
        repeat (60) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0)
                    set_req(c, 1'($urandom), $urandom, $urandom, MASK_W'($urandom));
            end
            begin
                int c;
                c = $urandom_range(0, NUM_CH - 1);
                if (pend[c] && $urandom_range(0, 5) == 0) pend[c] = 1'b0;
            end
            if (pend == '0) idle_cycle();
            else txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend != '0) txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        idle_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
        // memory accepts but never answers: error response, late answer ignored
        set_req(2, 1'b0, 32'h8000_7000, 32'h0, 4'hF);
        tmo_txn();
        idle_cycle();
        idle_cycle();
        set_req(0, 1'b0, 32'h8000_8000, 32'h0, 4'hF);
        txn(0, 0, 32'h0000_0413, 1'b0);
        idle_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
